// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - MEM stage shared types: FSM encoding and write-back select
package mem_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Also decoded by the WB stage, so the encoding is fixed here.
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_e;

    // Load data takes priority over the link value, which beats the ALU result.
    function automatic wb_sel_e wb_select(input logic mem2reg, input logic jump);
        if (mem2reg) begin
            return WB_SEL_MEM;
        end else if (jump) begin
            return WB_SEL_PC4;
        end else begin
            return WB_SEL_ALU;
        end
    endfunction

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// rtl/mem_stage_mem_wb_reg.sv - MEM/WB pipeline register with stall hold
module mem_wb_reg #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_hold,
    input  logic [BIT_W-1:0] i_wb_data,
    input  logic [4:0]       i_rd,
    input  logic             i_regwr,
    output logic [BIT_W-1:0] o_wb_data,
    output logic [4:0]       o_rd,
    output logic             o_regwr
);

    logic [BIT_W-1:0] r_wb_data;
    logic [4:0]       r_rd;
    logic             r_regwr;

    // Holding re-presents the same write to WB, which is harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_data <= '0;
            r_rd      <= '0;
            r_regwr   <= 1'b0;
        end else if (!i_hold) begin
            r_wb_data <= i_wb_data;
            r_rd      <= i_rd;
            r_regwr   <= i_regwr;
        end
    end

    assign o_wb_data = r_wb_data;
    assign o_rd      = r_rd;
    assign o_regwr   = r_regwr;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: D-cache request, write-back select, stall counter
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BIT_W  = 32,
    parameter int ADDR_W = 30,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIT_W-1:0]  alu_result_in,
    input  logic [BIT_W-1:0]  mem_wdata_in,
    input  logic [4:0]        rd_in,
    input  logic [BIT_W-1:0]  PC_plus_4_in,
    input  logic              memrd_in,
    input  logic              memwr_in,
    input  logic              mem2reg_in,
    input  logic              regwr_in,
    input  logic              jump_in,
    output logic              DCACHE_ren,
    output logic              DCACHE_wen,
    output logic [ADDR_W-1:0] DCACHE_addr,
    output logic [BIT_W-1:0]  DCACHE_wdata,
    input  logic [BIT_W-1:0]  DCACHE_rdata,
    input  logic              DCACHE_stall,
    output logic [BIT_W-1:0]  wb_data,
    output logic [4:0]        rd_out,
    output logic              regwr_out,
    output logic [BIT_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_req;
    logic             w_ren;
    logic             w_wen;
    logic [BIT_W-1:0] w_sel_data;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_req = memrd_in | memwr_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Upstream freezes EX/MEM while stalled, so the request inputs stay put in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_ren       = 1'b0;
        w_wen       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wen = memwr_in;
                w_ren = memrd_in & ~memwr_in;
                if (w_req && DCACHE_stall) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_wen = memwr_in;
                w_ren = memrd_in & ~memwr_in;
                if (!DCACHE_stall) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Requests are suppressed while reset is held, even if EX/MEM has not cleared yet.
    assign DCACHE_ren   = w_ren & rst_n;
    assign DCACHE_wen   = w_wen & rst_n;
    assign DCACHE_addr  = alu_result_in[BIT_W-1:2];
    assign DCACHE_wdata = mem_wdata_in;

    always_comb begin
        w_sel_data = alu_result_in;
        case (wb_select(mem2reg_in, jump_in))
            WB_SEL_MEM: w_sel_data = DCACHE_rdata;
            WB_SEL_PC4: w_sel_data = PC_plus_4_in;
            default:    w_sel_data = alu_result_in;
        endcase
    end

    assign fwd_data = w_sel_data;

    mem_wb_reg #(
        .BIT_W (BIT_W)
    ) u_mem_wb_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_hold    (DCACHE_stall),
        .i_wb_data (w_sel_data),
        .i_rd      (rd_in),
        .i_regwr   (regwr_in),
        .o_wb_data (wb_data),
        .o_rd      (rd_out),
        .o_regwr   (regwr_out)
    );

    // Free-running: counts refill/write-back stalls with no request too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (DCACHE_stall) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_result_in;
    logic [31:0] mem_wdata_in;
    logic [4:0]  rd_in;
    logic [31:0] PC_plus_4_in;
    logic        memrd_in;
    logic        memwr_in;
    logic        mem2reg_in;
    logic        regwr_in;
    logic        jump_in;
    logic [31:0] DCACHE_rdata;
    logic        DCACHE_stall;

    logic        DCACHE_ren, DCACHE_ren_4;
    logic        DCACHE_wen, DCACHE_wen_4;
    logic [29:0] DCACHE_addr, DCACHE_addr_4;
    logic [31:0] DCACHE_wdata, DCACHE_wdata_4;
    logic [31:0] wb_data, wb_data_4;
    logic [4:0]  rd_out, rd_out_4;
    logic        regwr_out, regwr_out_4;
    logic [31:0] fwd_data, fwd_data_4;
    logic [31:0] stall_cycles;
    logic [3:0]  stall_cycles_4;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
        .rd_in(rd_in), .PC_plus_4_in(PC_plus_4_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
        .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in),
        .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen), .DCACHE_addr(DCACHE_addr),
        .DCACHE_wdata(DCACHE_wdata), .DCACHE_rdata(DCACHE_rdata), .DCACHE_stall(DCACHE_stall),
        .wb_data(wb_data), .rd_out(rd_out), .regwr_out(regwr_out), .fwd_data(fwd_data),
        .stall_cycles(stall_cycles)
    );

    mem_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
        .rd_in(rd_in), .PC_plus_4_in(PC_plus_4_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
        .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in),
        .DCACHE_ren(DCACHE_ren_4), .DCACHE_wen(DCACHE_wen_4), .DCACHE_addr(DCACHE_addr_4),
        .DCACHE_wdata(DCACHE_wdata_4), .DCACHE_rdata(DCACHE_rdata), .DCACHE_stall(DCACHE_stall),
        .wb_data(wb_data_4), .rd_out(rd_out_4), .regwr_out(regwr_out_4), .fwd_data(fwd_data_4),
        .stall_cycles(stall_cycles_4)
    );

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        regwr;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_stall = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        alu_result_in = '0; mem_wdata_in = '0; rd_in = '0; PC_plus_4_in = '0;
        memrd_in = 0; memwr_in = 0; mem2reg_in = 0; regwr_in = 0; jump_in = 0;
        DCACHE_rdata = '0;
    endtask

    // Drive one EX/MEM instruction, hold it through n stall cycles, check its write-back.
    task automatic issue(input string name, input logic rd_i, input logic wr_i, input logic m2r,
                         input logic jmp, input logic rw, input logic [4:0] rdx,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] rdat, input int n);
        exp_t        e;
        exp_t        got;
        logic [31:0] prev_wb;
        logic        req;
        req = rd_i | wr_i;
        alu_result_in = alu; mem_wdata_in = wd; rd_in = rdx; PC_plus_4_in = pc4;
        memrd_in = rd_i; memwr_in = wr_i; mem2reg_in = m2r; regwr_in = rw; jump_in = jmp;
        DCACHE_stall = (n > 0);
        DCACHE_rdata = (n > 0) ? 32'hBAD0_BAD0 : rdat;
        e.wb    = m2r ? rdat : (jmp ? pc4 : alu);
        e.rd    = rdx;
        e.regwr = rw;
        sb.push_back(e);
        prev_wb = wb_data;
        #1;
        chk({name, ".ren"}, 32'(DCACHE_ren), 32'(rd_i & ~wr_i));
        chk({name, ".wen"}, 32'(DCACHE_wen), 32'(wr_i));
        if (req) begin
            chk({name, ".addr"}, 32'(DCACHE_addr), alu >> 2);
            chk({name, ".wdata"}, DCACHE_wdata, wd);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            exp_stall++;
            chk({name, ".state_wait"}, 32'(dut.r_state), 32'd1);
            chk({name, ".ren_held"}, 32'(DCACHE_ren), 32'(rd_i & ~wr_i));
            chk({name, ".wen_held"}, 32'(DCACHE_wen), 32'(wr_i));
            chk({name, ".addr_held"}, 32'(DCACHE_addr), alu >> 2);
            chk({name, ".wdata_held"}, DCACHE_wdata, wd);
            chk({name, ".wb_hold"}, wb_data, prev_wb);
            if (i == n - 1) begin
                DCACHE_stall = 0;
                DCACHE_rdata = rdat;
            end
            #1;
        end
        chk({name, ".fwd"}, fwd_data, e.wb);
        tick();
        got = sb.pop_front();
        chk({name, ".wb_data"}, wb_data, got.wb);
        chk({name, ".rd_out"}, 32'(rd_out), 32'(got.rd));
        chk({name, ".regwr_out"}, 32'(regwr_out), 32'(got.regwr));
        chk({name, ".state_idle"}, 32'(dut.r_state), 32'd0);
        chk({name, ".stall_cycles"}, stall_cycles, 32'(exp_stall));
        chk({name, ".stall_cycles_4"}, 32'(stall_cycles_4), 32'(exp_stall % 16));
    endtask

    initial begin
        logic [31:0] held;
        set_nop();
        DCACHE_stall = 0;
        rst_n = 0;
        #1;
        chk("reset.wb_data", wb_data, 32'd0);
        chk("reset.rd_out", 32'(rd_out), 32'd0);
        chk("reset.regwr_out", 32'(regwr_out), 32'd0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);
        chk("reset.ren", 32'(DCACHE_ren), 32'd0);
        chk("reset.wen", 32'(DCACHE_wen), 32'd0);
        chk("reset.state", 32'(dut.r_state), 32'd0);
        tick();
        tick();
        rst_n = 1;

        issue("load_hit",  1, 0, 1, 0, 1, 5'd5, 32'h10, 32'h0, 32'h0, 32'hDEAD_BEEF, 0);
        issue("load_miss", 1, 0, 1, 0, 1, 5'd6, 32'h10, 32'h0, 32'h0, 32'hCAFE_F00D, 3);
        issue("store",     0, 1, 0, 0, 0, 5'd0, 32'h20, 32'h1234_5678, 32'h0, 32'h0, 2);
        issue("jal",       0, 0, 0, 1, 1, 5'd1, 32'h55, 32'h0, 32'h104, 32'h0, 0);
        issue("alu_op",    0, 0, 0, 0, 1, 5'd7, 32'hABCD, 32'h0, 32'h0, 32'h0, 0);
        issue("rd_and_wr", 1, 1, 0, 0, 0, 5'd2, 32'h40, 32'h99, 32'h0, 32'h0, 1);
        issue("alu_op2",   0, 0, 0, 0, 1, 5'd8, 32'h77, 32'h0, 32'h0, 32'h0, 0);

        // Reset arrives while a load miss is waiting; EX/MEM inputs still show the load.
        alu_result_in = 32'h30; rd_in = 5'd9; memrd_in = 1; mem2reg_in = 1; regwr_in = 1;
        DCACHE_stall = 1;
        tick();
        chk("rst_mid.state_wait", 32'(dut.r_state), 32'd1);
        rst_n = 0;
        #1;
        chk("rst_mid.ren", 32'(DCACHE_ren), 32'd0);
        chk("rst_mid.wen", 32'(DCACHE_wen), 32'd0);
        chk("rst_mid.wb_data", wb_data, 32'd0);
        chk("rst_mid.regwr_out", 32'(regwr_out), 32'd0);
        chk("rst_mid.stall_cycles", stall_cycles, 32'd0);
        chk("rst_mid.stall_cycles_4", 32'(stall_cycles_4), 32'd0);
        chk("rst_mid.state", 32'(dut.r_state), 32'd0);
        set_nop();
        DCACHE_stall = 0;
        tick();
        rst_n = 1;
        exp_stall = 0;
        sb.delete();

        issue("post_rst_alu", 0, 0, 0, 0, 1, 5'd4, 32'h1111, 32'h0, 32'h0, 32'h0, 0);

        // Cache-internal stall with no request: counted, MEM/WB held, FSM idle.
        set_nop();
        held = wb_data;
        DCACHE_stall = 1;
        for (int i = 0; i < 17; i++) begin
            tick();
            exp_stall++;
        end
        chk("idle_stall.state", 32'(dut.r_state), 32'd0);
        chk("idle_stall.wb_hold", wb_data, held);
        chk("idle_stall.ren", 32'(DCACHE_ren), 32'd0);
        chk("idle_stall.count", stall_cycles, 32'd17);
        chk("idle_stall.wrap4", 32'(stall_cycles_4), 32'd1);

        issue("load_hit2", 1, 0, 1, 0, 1, 5'd3, 32'h10, 32'h0, 32'h0, 32'h0BAD_F00D, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
